writeback_sequencer: RTL and testbench

Writer-side front end of the register bank. It merges single-cycle ALU results and variable-latency load results into one register-bank write per cycle, driving the bank's wrReg/rd/rdIn inputs. A load-result FIFO absorbs collisions. A per-register pending scoreboard produces the decode-stage stall for RAW hazards on outstanding loads.

---
 rtl/writeback_sequencer_if.sv | 32 +++
 rtl/writeback_sequencer.sv | 120 ++++++++++++
 tb/tb_writeback_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_sequencer_if.sv
// Writer-side bus of the register bank: ALU results, load results, decode scoreboard
// probes and the registered register-bank write port.
interface writeback_sequencer_if;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        memValid;
  logic        memReady;
  logic [4:0]  memRd;
  logic [31:0] memData;
  logic        issueLoad;
  logic [4:0]  issueRd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        stall;
  logic        wrReg;
  logic [4:0]  rd;
  logic [31:0] rdIn;
  logic        aluHold;

  modport master (
    output aluValid, aluRd, aluData, memValid, memRd, memData,
           issueLoad, issueRd, rs, rt,
    input  memReady, stall, wrReg, rd, rdIn, aluHold
  );

  modport slave (
    input  aluValid, aluRd, aluData, memValid, memRd, memData,
           issueLoad, issueRd, rs, rt,
    output memReady, stall, wrReg, rd, rdIn, aluHold
  );
endinterface

// File: rtl/writeback_sequencer.sv
// Merges ALU results and buffered load results into one register-bank write per cycle,
// with a load-pending scoreboard for decode stalls. Optional starvation guard: WB_STARVE_GUARD_EN.
module writeback_sequencer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic                  clk,
  input logic                  rst,
  writeback_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [4:0]   fifo_rd   [DEPTH];
  logic [31:0]  fifo_data [DEPTH];
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [4:0]   head_rd;
  logic [31:0]  head_data;
  logic [31:0]  pending;
  logic [31:0]  pending_next;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push      = bus.memValid && !full;
  assign pop       = !bus.aluValid && !empty;
  assign head_rd   = fifo_rd[rptr[AW-1:0]];
  assign head_data = fifo_data[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr[AW-1:0]]   <= bus.memRd;
      fifo_data[wptr[AW-1:0]] <= bus.memData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (bus.aluValid) begin
      wr_en   <= (bus.aluRd != 5'd0);
      wr_addr <= bus.aluRd;
      wr_data <= bus.aluData;
    end else if (pop) begin
      wr_en   <= (head_rd != 5'd0);
      wr_addr <= head_rd;
      wr_data <= head_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Clear before set so a same-edge issue to the retiring register keeps it pending.
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head_rd] = 1'b0;
    if (bus.issueLoad && (bus.issueRd != 5'd0)) pending_next[bus.issueRd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_next;
  end

  assign bus.memReady = !full;
  assign bus.stall    = pending[bus.rs] | pending[bus.rt];
  assign bus.wrReg    = wr_en;
  assign bus.rd       = wr_addr;
  assign bus.rdIn     = wr_data;

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned        CW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]      LAST = CW'(STARVE_LIMIT - 1);

  logic [CW-1:0] starve_cnt;
  logic          hold;

  // A non-empty FIFO that does not pop this cycle has necessarily lost to aluValid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      hold       <= 1'b0;
    end else begin
      hold <= 1'b0;
      if (empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt == LAST) begin
        starve_cnt <= '0;
        hold       <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign bus.aluHold = hold;
`else
  assign bus.aluHold = 1'b0;
`endif
endmodule

// File: tb/tb_writeback_sequencer.sv
// Self-checking bench for writeback_sequencer: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_writeback_sequencer;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 3;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  writeback_sequencer_if bus ();

  writeback_sequencer #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [36:0] q [$];
  logic [31:0] pend;
  logic        m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_hold;
  int unsigned m_cnt;

  task automatic model_clear();
    q.delete();
    pend   = '0;
    m_wr   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    m_hold = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic idle();
    bus.aluValid  = 1'b0; bus.aluRd = '0; bus.aluData = '0;
    bus.memValid  = 1'b0; bus.memRd = '0; bus.memData = '0;
    bus.issueLoad = 1'b0; bus.issueRd = '0;
    bus.rs = '0; bus.rt = '0;
  endtask

  // Advance the model by one clock edge from the current inputs, then step the DUT.
  task automatic tick();
    bit          do_pop, do_push, was_empty;
    logic [36:0] head;
    was_empty = (q.size() == 0);
    do_pop    = !bus.aluValid && !was_empty;
    do_push   = bus.memValid && (q.size() < DEPTH);
    if (GUARD) begin
      m_hold = 1'b0;
      if (was_empty || do_pop) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt == STARVE_LIMIT) begin m_hold = 1'b1; m_cnt = 0; end
      end
    end else m_hold = 1'b0;
    if (bus.aluValid) begin
      m_wr = (bus.aluRd != 0); m_rd = bus.aluRd; m_data = bus.aluData;
    end else if (do_pop) begin
      head = q.pop_front();
      m_wr = (head[36:32] != 0); m_rd = head[36:32]; m_data = head[31:0];
      pend[head[36:32]] = 1'b0;
    end else m_wr = 1'b0;
    if (bus.issueLoad && bus.issueRd != 0) pend[bus.issueRd] = 1'b1;
    if (do_push) q.push_back({bus.memRd, bus.memData});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus.wrReg !== 1'b0) begin failures++; $display("FAIL reset_wrReg: got %b want 0", bus.wrReg); end
    checks++; if (bus.rd !== 5'd0) begin failures++; $display("FAIL reset_rd: got %0d want 0", bus.rd); end
    checks++; if (bus.rdIn !== 32'd0) begin failures++; $display("FAIL reset_rdIn: got %h want 0", bus.rdIn); end
    checks++; if (bus.memReady !== 1'b1) begin failures++; $display("FAIL reset_memReady: got %b want 1", bus.memReady); end
    checks++; if (bus.aluHold !== 1'b0) begin failures++; $display("FAIL reset_aluHold: got %b want 0", bus.aluHold); end
  endtask

  task automatic test_alu_write();
    bus.aluValid = 1'b1; bus.aluRd = 5'd1; bus.aluData = 32'hDEADBEEF;
    tick();
    bus.aluValid = 1'b0;
    checks++; if (bus.wrReg !== 1'b1) begin failures++; $display("FAIL alu_wrReg: got %b want 1", bus.wrReg); end
    checks++; if (bus.rd !== 5'd1) begin failures++; $display("FAIL alu_rd: got %0d want 1", bus.rd); end
    checks++; if (bus.rdIn !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_rdIn: got %h want deadbeef", bus.rdIn); end
    for (int i = 0; i < 32; i++) begin
      bus.rs = 5'(i); bus.rt = 5'(31 - i);
      #0.1;
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL idle_stall rs=%0d: got %b want 0", i, bus.stall); end
    end
    idle();
  endtask

  task automatic test_load_latency();
    bus.issueLoad = 1'b1; bus.issueRd = 5'd5;
    tick();
    bus.issueLoad = 1'b0; bus.rs = 5'd5;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL raw_stall: got %b want 1", bus.stall); end
    bus.memValid = 1'b1; bus.memRd = 5'd5; bus.memData = 32'hCAFEBABE;
    tick();
    bus.memValid = 1'b0;
    checks++; if (bus.wrReg !== 1'b0) begin failures++; $display("FAIL load_early: got wrReg %b want 0", bus.wrReg); end
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_hold: got %b want 1", bus.stall); end
    tick();
    checks++; if (bus.wrReg !== 1'b1 || bus.rd !== 5'd5 || bus.rdIn !== 32'hCAFEBABE) begin
      failures++; $display("FAIL load_write: got %b/%0d/%h want 1/5/cafebabe", bus.wrReg, bus.rd, bus.rdIn); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL stall_clear: got %b want 0", bus.stall); end
    idle();
  endtask

  task automatic test_collision();
    bus.aluValid = 1'b1; bus.aluRd = 5'd3; bus.aluData = 32'h11111111;
    bus.memValid = 1'b1; bus.memRd = 5'd4; bus.memData = 32'h22222222;
    tick();
    idle();
    checks++; if (bus.wrReg !== 1'b1 || bus.rd !== 5'd3 || bus.rdIn !== 32'h11111111) begin
      failures++; $display("FAIL collide_first: got %b/%0d/%h want 1/3/11111111", bus.wrReg, bus.rd, bus.rdIn); end
    tick();
    checks++; if (bus.wrReg !== 1'b1 || bus.rd !== 5'd4 || bus.rdIn !== 32'h22222222) begin
      failures++; $display("FAIL collide_second: got %b/%0d/%h want 1/4/22222222", bus.wrReg, bus.rd, bus.rdIn); end
  endtask

  task automatic test_fifo_full();
    int  got;
    bit  ready;
    logic [31:0] want_data;
    reset_dut();
    bus.aluValid = 1'b1; bus.aluRd = 5'd7;
    for (int i = 0; i < 4; i++) begin
      bus.aluData = $urandom; bus.memValid = 1'b1;
      bus.memRd = 5'(10 + i); bus.memData = 32'h1000_0000 + 32'(i);
      tick();
    end
    bus.memRd = 5'd14; bus.memData = 32'h1000_0004;
    checks++; if (bus.memReady !== 1'b0) begin failures++; $display("FAIL full_ready: got %b want 0", bus.memReady); end
    repeat (2) tick();
    checks++; if (bus.memReady !== 1'b0) begin failures++; $display("FAIL full_hold: got %b want 0", bus.memReady); end
    checks++; if (bus.wrReg !== 1'b1 || bus.rd !== 5'd7) begin
      failures++; $display("FAIL full_alu_wins: got %b/%0d want 1/7", bus.wrReg, bus.rd); end
    bus.aluValid = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      ready = bus.memValid && (q.size() < DEPTH);
      tick();
      if (ready) bus.memValid = 1'b0;
      if (bus.wrReg === 1'b1) begin
        want_data = 32'h1000_0000 + 32'(got);
        checks++; if (bus.rd !== 5'(10 + got) || bus.rdIn !== want_data) begin
          failures++; $display("FAIL drain_order[%0d]: got %0d/%h want %0d/%h", got, bus.rd, bus.rdIn, 10 + got, want_data); end
        got++;
      end
    end
    checks++; if (got != 5) begin failures++; $display("FAIL drain_count: got %0d want 5", got); end
    idle();
  endtask

  task automatic test_x0();
    reset_dut();
    bus.aluValid = 1'b1; bus.aluRd = 5'd0; bus.aluData = 32'hFFFFFFFF;
    bus.issueLoad = 1'b1; bus.issueRd = 5'd0;
    tick();
    idle();
    checks++; if (bus.wrReg !== 1'b0) begin failures++; $display("FAIL x0_alu: got wrReg %b want 0", bus.wrReg); end
    bus.memValid = 1'b1; bus.memRd = 5'd0; bus.memData = 32'h12345678;
    tick();
    idle();
    tick();
    checks++; if (bus.wrReg !== 1'b0) begin failures++; $display("FAIL x0_load: got wrReg %b want 0", bus.wrReg); end
    // A full FIFO of 4 with ALU blocking would show memReady=0 only if the x0 entry lingered.
    bus.aluValid = 1'b1; bus.aluRd = 5'd2;
    for (int i = 0; i < 3; i++) begin
      bus.memValid = 1'b1; bus.memRd = 5'd9; bus.memData = 32'(i);
      tick();
    end
    idle();
    checks++; if (bus.memReady !== 1'b1) begin failures++; $display("FAIL x0_consumed: got memReady %b want 1", bus.memReady); end
    bus.rs = 5'd0; bus.rt = 5'd0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL x0_stall: got %b want 0", bus.stall); end
    repeat (4) tick();
  endtask

  task automatic test_starve();
    logic want;
    reset_dut();
    bus.aluValid = 1'b1; bus.aluRd = 5'd2; bus.aluData = 32'h0BAD_F00D;
    bus.memValid = 1'b1; bus.memRd = 5'd9; bus.memData = 32'h5A5A5A5A;
    tick();
    bus.memValid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      want = GUARD && (k == 3);
      checks++; if (bus.aluHold !== want) begin failures++; $display("FAIL starve_hold k=%0d: got %b want %b", k, bus.aluHold, want); end
    end
    bus.aluValid = 1'b0;
    tick();
    checks++; if (bus.wrReg !== 1'b1 || bus.rd !== 5'd9 || bus.rdIn !== 32'h5A5A5A5A) begin
      failures++; $display("FAIL starve_drain: got %b/%0d/%h want 1/9/5a5a5a5a", bus.wrReg, bus.rd, bus.rdIn); end
    checks++; if (bus.aluHold !== 1'b0) begin failures++; $display("FAIL starve_one_cycle: got %b want 0", bus.aluHold); end
    idle();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    bus.issueLoad = 1'b1; bus.issueRd = 5'd6;
    bus.aluValid = 1'b1; bus.aluRd = 5'd1; bus.aluData = 32'hA5A5A5A5;
    bus.memValid = 1'b1; bus.memRd = 5'd6; bus.memData = 32'h66666666;
    tick();
    bus.issueLoad = 1'b0; bus.memRd = 5'd8;
    tick();
    bus.memValid = 1'b0; bus.rs = 5'd6;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.wrReg !== 1'b1) begin
      failures++; $display("FAIL pre_reset: got stall %b wrReg %b want 1 1", bus.stall, bus.wrReg); end
    rst = 1'b0;
    #1;
    checks++; if (bus.wrReg !== 1'b0 || bus.rd !== 5'd0 || bus.rdIn !== 32'd0) begin
      failures++; $display("FAIL async_reset_out: got %b/%0d/%h want 0/0/0", bus.wrReg, bus.rd, bus.rdIn); end
    checks++; if (bus.memReady !== 1'b1 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL async_reset_state: got ready %b stall %b want 1 0", bus.memReady, bus.stall); end
    model_clear();
    bus.aluValid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    checks++; if (bus.wrReg !== 1'b0) begin failures++; $display("FAIL reset_discard: got wrReg %b want 0", bus.wrReg); end
    idle();
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      bus.aluValid  = ($urandom_range(0, 99) < 45);
      bus.aluRd     = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      bus.aluData   = $urandom;
      bus.memValid  = ($urandom_range(0, 99) < 50);
      bus.memRd     = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      bus.memData   = $urandom;
      bus.issueLoad = ($urandom_range(0, 99) < 30);
      bus.issueRd   = 5'($urandom);
      bus.rs        = 5'($urandom);
      bus.rt        = 5'($urandom);
      #1;
      checks++; if (bus.stall !== (pend[bus.rs] | pend[bus.rt])) begin
        failures++; $display("FAIL rand_stall n=%0d: got %b want %b", n, bus.stall, pend[bus.rs] | pend[bus.rt]); end
      checks++; if (bus.memReady !== (q.size() < DEPTH)) begin
        failures++; $display("FAIL rand_ready n=%0d: got %b want %b", n, bus.memReady, q.size() < DEPTH); end
      tick();
      checks++; if (bus.wrReg !== m_wr || bus.aluHold !== m_hold) begin
        failures++; $display("FAIL rand_ctl n=%0d: got wr %b hold %b want %b %b", n, bus.wrReg, bus.aluHold, m_wr, m_hold); end
      if (m_wr) begin
        checks++; if (bus.rd !== m_rd || bus.rdIn !== m_data) begin
          failures++; $display("FAIL rand_data n=%0d: got %0d/%h want %0d/%h", n, bus.rd, bus.rdIn, m_rd, m_data); end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    model_clear();
    test_reset();
    test_alu_write();
    test_load_latency();
    test_collision();
    test_fifo_full();
    test_x0();
    test_starve();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
